// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
//   Push/pull sequencer for PSHS/PSHU/PULS/PULU and interrupt entry/RTI
//   stacking. Walks the register-select postbyte one byte per memory access.
//   Push scans b7..b0 (16-bit registers low byte first), pull scans b0..b7
//   (16-bit registers high byte first).
//
// Ports
//   clk_in, rst_in         clock (rising edge), asynchronous active-high reset
//   start/pull/use_s_i     command; pull and stack select latched on start
//   mask                   postbyte: b7 PC, b6 U/S(other), b5 Y, b4 X,
//                          b3 DP, b2 B, b1 A, b0 CC
//   path_left_addr/_data   register read path into the register block
//   reg_su                 current stack pointer from the register block
//   write_reg/_addr,data_w register write port (pulled values)
//   use_s, inc_su, dec_su  stack select and pointer step strobes
//   mem_*                  byte-wide data memory port, strobes held to mem_rdy
//   busy, done, err        status; err pulses with done on a timeout abort
// -----------------------------------------------------------------------------
module stack_seq #(
    parameter int TIMEOUT = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic        pull,
    input  logic        use_s_i,
    input  logic [7:0]  mask,
    input  logic [15:0] path_left_data,
    input  logic [15:0] reg_su,
    input  logic [7:0]  mem_din,
    input  logic        mem_rdy,
    output logic [3:0]  path_left_addr,
    output logic        write_reg,
    output logic [3:0]  write_reg_addr,
    output logic [15:0] data_w,
    output logic        use_s,
    output logic        inc_su,
    output logic        dec_su,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_we,
    output logic        mem_oe,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_WR,
        S_RD,
        S_INC,
        S_DONE
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'h0000;

    state_t      state;
    logic [7:0]  pend;      // mask bits still to be transferred
    logic        pull_q;
    logic [2:0]  cur;       // mask bit being transferred
    logic        second;    // second byte of a 16-bit register
    logic [7:0]  hold;      // high byte of a 16-bit pull
    logic [15:0] wait_cnt;

    logic        cur_wide;
    logic        cur_last;
    logic        advance;
    logic        to_fire;
    logic [7:0]  sel_mask;
    logic        sel_pull;
    logic        sel_us;
    logic [3:0]  pick;
    logic        sel_any;
    logic [2:0]  sel_idx;
    logic [3:0]  sel_code;

    // Next mask bit to service: lowest set bit for pull, highest for push.
    function automatic logic [3:0] pick_bit(input logic [7:0] m, input logic pl);
        logic [3:0] r;
        r = 4'h0;
        if (pl) begin
            for (int i = 7; i >= 0; i--)
                if (m[i]) r = {1'b1, 3'(i)};
        end else begin
            for (int i = 0; i < 8; i++)
                if (m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // Mask bit -> register code; b6 names the stack not being walked.
    function automatic logic [3:0] reg_code(input logic [2:0] idx, input logic us);
        logic [3:0] c;
        case (idx)
            3'd7:    c = 4'd5;
            3'd6:    c = us ? 4'd3 : 4'd4;
            3'd5:    c = 4'd2;
            3'd4:    c = 4'd1;
            3'd3:    c = 4'd11;
            3'd2:    c = 4'd9;
            3'd1:    c = 4'd8;
            default: c = 4'd10;
        endcase
        return c;
    endfunction

    // The SEL step is folded into whichever state hands control back to it,
    // so selection is evaluated combinationally from the post-clear mask.
    always_comb begin
        cur_wide = cur[2];
        cur_last = !cur_wide || second;
        sel_mask = pend & ~(8'h01 << cur);
        sel_pull = pull_q;
        sel_us   = use_s;
        if (state == S_IDLE) begin
            sel_mask = mask;
            sel_pull = pull;
            sel_us   = use_s_i;
        end
        pick     = pick_bit(sel_mask, sel_pull);
        sel_any  = pick[3];
        sel_idx  = pick[2:0];
        sel_code = reg_code(sel_idx, sel_us);
        case (state)
            S_IDLE:  advance = start;
            S_WR:    advance = mem_rdy && cur_last;
            S_INC:   advance = cur_last;
            default: advance = 1'b0;
        endcase
        to_fire = TO_EN && (state == S_WR || state == S_RD) && !mem_rdy &&
                  (wait_cnt == TO_LAST);
    end

    // Address and push data come straight from the register block so that the
    // pointer already stepped by the preceding DEC is used.
    assign mem_addr = (state == S_WR || state == S_RD) ? reg_su : 16'h0000;
    assign mem_dout = (state != S_WR) ? 8'h00 :
                      (cur_wide && second) ? path_left_data[15:8] : path_left_data[7:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= S_IDLE;
            pend           <= 8'h00;
            pull_q         <= 1'b0;
            cur            <= 3'd0;
            second         <= 1'b0;
            hold           <= 8'h00;
            wait_cnt       <= 16'h0000;
            path_left_addr <= 4'h0;
            write_reg      <= 1'b0;
            write_reg_addr <= 4'h0;
            data_w         <= 16'h0000;
            use_s          <= 1'b0;
            inc_su         <= 1'b0;
            dec_su         <= 1'b0;
            mem_we         <= 1'b0;
            mem_oe         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            dec_su    <= 1'b0;
            inc_su    <= 1'b0;
            write_reg <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            if (advance) begin
                pend     <= sel_mask;
                cur      <= sel_idx;
                second   <= 1'b0;
                wait_cnt <= 16'h0000;
                mem_we   <= 1'b0;
                if (state == S_IDLE) begin
                    pull_q <= pull;
                    use_s  <= use_s_i;
                end
                if (!sel_any) begin
                    state          <= S_DONE;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    path_left_addr <= 4'hF;
                end else if (sel_pull) begin
                    state          <= S_RD;
                    mem_oe         <= 1'b1;
                    busy           <= 1'b1;
                    path_left_addr <= 4'hF;
                end else begin
                    state          <= S_DEC;
                    dec_su         <= 1'b1;
                    busy           <= 1'b1;
                    path_left_addr <= sel_code;
                end
            end else if (to_fire) begin
                // Abort: drop remaining bits, keep pointer steps already taken.
                state          <= S_DONE;
                done           <= 1'b1;
                err            <= 1'b1;
                busy           <= 1'b0;
                mem_we         <= 1'b0;
                mem_oe         <= 1'b0;
                pend           <= 8'h00;
                path_left_addr <= 4'hF;
            end else begin
                case (state)
                    S_DEC: begin
                        state    <= S_WR;
                        mem_we   <= 1'b1;
                        wait_cnt <= 16'h0000;
                    end
                    S_WR: begin
                        if (mem_rdy) begin
                            // Low byte of a 16-bit push done; step again for high.
                            mem_we <= 1'b0;
                            second <= 1'b1;
                            dec_su <= 1'b1;
                            state  <= S_DEC;
                        end else begin
                            wait_cnt <= wait_cnt + 16'h0001;
                        end
                    end
                    S_RD: begin
                        if (mem_rdy) begin
                            mem_oe <= 1'b0;
                            inc_su <= 1'b1;
                            state  <= S_INC;
                            if (cur_wide && !second) begin
                                hold <= mem_din;
                            end else begin
                                data_w         <= cur_wide ? {hold, mem_din} : {8'h00, mem_din};
                                write_reg      <= 1'b1;
                                write_reg_addr <= reg_code(cur, use_s);
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 16'h0001;
                        end
                    end
                    S_INC: begin
                        // High byte of a 16-bit pull done; fetch the low byte.
                        second   <= 1'b1;
                        mem_oe   <= 1'b1;
                        wait_cnt <= 16'h0000;
                        state    <= S_RD;
                    end
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
module tb_stack_seq;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start = 1'b0, pull = 1'b0, use_s_i = 1'b0, mem_rdy = 1'b1;
    logic [7:0]  mask = 8'h00;
    logic [7:0]  mem_din;
    logic [15:0] path_left_data, reg_su;
    logic [3:0]  path_left_addr, write_reg_addr;
    logic        write_reg, use_s, inc_su, dec_su, mem_we, mem_oe, busy, done, err;
    logic [15:0] data_w, mem_addr;
    logic [7:0]  mem_dout;

    // second instance with a finite timeout, fed a memory that never answers
    logic        st2 = 1'b0;
    logic [7:0]  mask2 = 8'h80;
    logic [7:0]  din2 = 8'h00;
    logic        rdy2 = 1'b0;
    logic [15:0] pld2 = 16'h1234, su2 = 16'h0100;
    logic [3:0]  pla2, wra2;
    logic        wr2, us2, inc2, dec2, we2, oe2, busy2, done2, err2;
    logic [15:0] dw2, ma2;
    logic [7:0]  md2;

    always #5 clk_in = ~clk_in;

    stack_seq #(.TIMEOUT(0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .pull(pull), .use_s_i(use_s_i),
        .mask(mask), .path_left_data(path_left_data), .reg_su(reg_su), .mem_din(mem_din),
        .mem_rdy(mem_rdy), .path_left_addr(path_left_addr), .write_reg(write_reg),
        .write_reg_addr(write_reg_addr), .data_w(data_w), .use_s(use_s), .inc_su(inc_su),
        .dec_su(dec_su), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we),
        .mem_oe(mem_oe), .busy(busy), .done(done), .err(err)
    );

    stack_seq #(.TIMEOUT(4)) u_to (
        .clk_in(clk_in), .rst_in(rst_in), .start(st2), .pull(1'b0), .use_s_i(1'b1),
        .mask(mask2), .path_left_data(pld2), .reg_su(su2), .mem_din(din2),
        .mem_rdy(rdy2), .path_left_addr(pla2), .write_reg(wr2),
        .write_reg_addr(wra2), .data_w(dw2), .use_s(us2), .inc_su(inc2),
        .dec_su(dec2), .mem_addr(ma2), .mem_dout(md2), .mem_we(we2),
        .mem_oe(oe2), .busy(busy2), .done(done2), .err(err2)
    );

    // ---------------- register block and memory environment ----------------
    bit [15:0] rf [16];
    bit [15:0] ld_vals [16];
    bit        ld = 1'b0;
    bit [7:0]  mem [65536];

    assign path_left_data = rf[path_left_addr];
    assign reg_su         = use_s ? rf[4] : rf[3];
    assign mem_din        = mem[mem_addr];

    always @(posedge clk_in) begin
        if (ld) begin
            for (int i = 0; i < 16; i++) rf[i] <= ld_vals[i];
        end else begin
            if (write_reg) rf[write_reg_addr] <= data_w;
            if (dec_su) begin
                if (use_s) rf[4] <= rf[4] - 16'd1; else rf[3] <= rf[3] - 16'd1;
            end
            if (inc_su) begin
                if (use_s) rf[4] <= rf[4] + 16'd1; else rf[3] <= rf[3] + 16'd1;
            end
        end
        if (mem_we && mem_rdy) mem[mem_addr] <= mem_dout;
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct { bit [15:0] a; bit [7:0] d; } wr_t;
    typedef struct { bit [3:0] r; bit [15:0] v; } rw_t;
    typedef struct {
        bit pl; bit us; bit [7:0] m; bit [15:0] sp0; bit spec; int exp_done; bit [15:0] exp_sp;
    } vec_t;

    wr_t exp_wr[$], got_wr[$];
    rw_t exp_rw[$], got_rw[$];
    int  n_chk = 0, n_fail = 0;
    int  oe_n, inc_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit [3:0] code_of(input int b, input bit us);
        case (b)
            7: return 4'd5;
            6: return us ? 4'd3 : 4'd4;
            5: return 4'd2;
            4: return 4'd1;
            3: return 4'd11;
            2: return 4'd9;
            1: return 4'd8;
            default: return 4'd10;
        endcase
    endfunction

    // Expected memory traffic / register writes straight from the stacking rules.
    task automatic build_expect(input bit pl, input bit us, input bit [7:0] m,
                                output int nb, output bit [15:0] sp);
        bit [15:0] v;
        exp_wr.delete();
        exp_rw.delete();
        sp = us ? rf[4] : rf[3];
        nb = 0;
        if (!pl) begin
            for (int b = 7; b >= 0; b--) if (m[b]) begin
                v = rf[code_of(b, us)];
                sp = sp - 16'd1; exp_wr.push_back('{sp, v[7:0]}); nb++;
                if (b >= 4) begin
                    sp = sp - 16'd1; exp_wr.push_back('{sp, v[15:8]}); nb++;
                end
            end
        end else begin
            for (int b = 0; b < 8; b++) if (m[b]) begin
                if (b >= 4) begin
                    v = {mem[sp], mem[sp + 16'd1]}; sp = sp + 16'd2; nb += 2;
                end else begin
                    v = {8'h00, mem[sp]}; sp = sp + 16'd1; nb++;
                end
                exp_rw.push_back('{code_of(b, us), v});
            end
        end
    endtask

    task automatic do_load();
        @(negedge clk_in) ld = 1'b1;
        @(negedge clk_in) ld = 1'b0;
    endtask

    task automatic set_regs(input bit spec, input bit us, input bit [15:0] sp0);
        for (int i = 0; i < 16; i++) ld_vals[i] = 16'h0000;
        if (spec) begin
            ld_vals[5] = 16'h1234; ld_vals[3] = 16'h0E00; ld_vals[4] = 16'h0F00;
            ld_vals[2] = 16'hA55A; ld_vals[1] = 16'h0001; ld_vals[11] = 16'h0000;
            ld_vals[9] = 16'h0022; ld_vals[8] = 16'h0011; ld_vals[10] = 16'h0080;
        end
        ld_vals[us ? 4 : 3] = sp0;
        do_load();
    endtask

    // rmode: 0 = memory always ready, 1 = random stalls, 2 = first 3 access cycles stalled
    task automatic run_op(input bit pl, input bit us, input bit [7:0] m, input int rmode,
                          input string tag, output int done_c);
        int c, stalls, busy_n, viol, nb;
        bit err_seen;
        bit [15:0] sp_exp;
        build_expect(pl, us, m, nb, sp_exp);
        got_wr.delete(); got_rw.delete();
        oe_n = 0; inc_n = 0;
        @(negedge clk_in);
        start = 1'b1; pull = pl; use_s_i = us; mask = m; mem_rdy = 1'b1;
        c = 0; stalls = 0; busy_n = 0; viol = 0; done_c = -1; err_seen = 1'b0;
        while (c < 400) begin
            @(negedge clk_in);
            c++;
            start   = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            pull    = 1'($urandom_range(0, 1));
            use_s_i = 1'($urandom_range(0, 1));
            mask    = 8'($urandom);
            case (rmode)
                0:       mem_rdy = 1'b1;
                1:       mem_rdy = ($urandom_range(0, 2) != 0);
                default: mem_rdy = (c > 3);
            endcase
            if ((mem_we && mem_oe) || (inc_su && dec_su)) viol++;
            if (busy) busy_n++;
            if (mem_oe) oe_n++;
            if (inc_su) inc_n++;
            if ((mem_we || mem_oe) && !mem_rdy) stalls++;
            if (mem_we && mem_rdy) got_wr.push_back('{mem_addr, mem_dout});
            if (write_reg) got_rw.push_back('{write_reg_addr, data_w});
            if (done) begin
                done_c = c;
                err_seen = err;
                break;
            end
        end
        start = 1'b0;
        check({tag, " done cycle"}, done_c, 1 + 2 * nb + stalls);
        check({tag, " err"}, err_seen, 1'b0);
        check({tag, " strobe overlap"}, viol, 0);
        check({tag, " busy cycles"}, busy_n, (nb > 0) ? done_c - 1 : 0);
        check({tag, " use_s"}, use_s, us);
        check({tag, " final sp"}, us ? rf[4] : rf[3], sp_exp);
        check({tag, " write count"}, got_wr.size(), exp_wr.size());
        if (got_wr.size() == exp_wr.size())
            foreach (exp_wr[i]) begin
                check($sformatf("%s wr%0d addr", tag, i), got_wr[i].a, exp_wr[i].a);
                check($sformatf("%s wr%0d data", tag, i), got_wr[i].d, exp_wr[i].d);
            end
        check({tag, " reg write count"}, got_rw.size(), exp_rw.size());
        if (got_rw.size() == exp_rw.size())
            foreach (exp_rw[i]) begin
                check($sformatf("%s rw%0d reg", tag, i), got_rw[i].r, exp_rw[i].r);
                check($sformatf("%s rw%0d val", tag, i), got_rw[i].v, exp_rw[i].v);
            end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t vt[7];
        bit [7:0]  push_bytes[12];
        rw_t       pull_regs[8];
        int        dc, ec, dec_n, we_n, err_n;
        bit [15:0] sp0;
        bit        us;

        vt[0] = '{1'b0, 1'b1, 8'hFF, 16'h0F00, 1'b1, 25, 16'h0EF4};
        vt[1] = '{1'b1, 1'b1, 8'hFF, 16'h0EF4, 1'b0, 25, 16'h0F00};
        vt[2] = '{1'b0, 1'b0, 8'h00, 16'h2000, 1'b1, 1,  16'h2000};
        vt[3] = '{1'b0, 1'b0, 8'h81, 16'h2000, 1'b1, 7,  16'h1FFD};
        vt[4] = '{1'b1, 1'b0, 8'h80, 16'h1FFD, 1'b1, 5,  16'h1FFF};
        vt[5] = '{1'b0, 1'b0, 8'h40, 16'h3000, 1'b1, 5,  16'h2FFE};
        vt[6] = '{1'b1, 1'b1, 8'h0C, 16'h0EF4, 1'b1, 5,  16'h0EF6};
        push_bytes = '{8'h34, 8'h12, 8'h00, 8'h0E, 8'h5A, 8'hA5,
                       8'h01, 8'h00, 8'h00, 8'h22, 8'h11, 8'h80};
        pull_regs = '{'{4'd10, 16'h0080}, '{4'd8, 16'h0011}, '{4'd9, 16'h0022},
                      '{4'd11, 16'h0000}, '{4'd1, 16'h0001}, '{4'd2, 16'hA55A},
                      '{4'd3, 16'h0E00}, '{4'd5, 16'h1234}};

        // reset state of both instances
        #2;
        check("reset ctrl", {busy, done, err, mem_we, mem_oe, inc_su, dec_su, write_reg, use_s}, 0);
        check("reset addr", {path_left_addr, write_reg_addr, mem_addr, mem_dout, data_w}, 0);
        check("reset u_to", {busy2, done2, err2, we2, oe2, inc2, dec2, wr2, us2,
                             pla2, wra2, ma2, md2, dw2}, 0);
        @(negedge clk_in) rst_in = 1'b0;

        // table-driven directed operations
        for (int t = 0; t < 7; t++) begin
            set_regs(vt[t].spec, vt[t].us, vt[t].sp0);
            run_op(vt[t].pl, vt[t].us, vt[t].m, 0, $sformatf("vec%0d", t), dc);
            check($sformatf("vec%0d table done", t), dc, vt[t].exp_done);
            check($sformatf("vec%0d table sp", t), vt[t].us ? rf[4] : rf[3], vt[t].exp_sp);
            if (t == 0)
                for (int i = 0; i < 12; i++)
                    check($sformatf("push mem %0h", 16'h0EFF - 16'(i)),
                          mem[16'h0EFF - 16'(i)], push_bytes[i]);
            if (t == 1 && got_rw.size() == 8)
                for (int i = 0; i < 8; i++) begin
                    check($sformatf("pull order %0d reg", i), got_rw[i].r, pull_regs[i].r);
                    check($sformatf("pull order %0d val", i), got_rw[i].v, pull_regs[i].v);
                end
        end

        // pull A with three stalled cycles
        set_regs(1'b1, 1'b1, 16'h0EF4);
        run_op(1'b1, 1'b1, 8'h02, 2, "stall", dc);
        check("stall done cycle", dc, 6);
        check("stall oe cycles", oe_n, 4);
        check("stall inc count", inc_n, 1);
        check("stall A value", rf[8], 16'h0080);

        // timeout abort on the TIMEOUT=4 instance
        @(negedge clk_in) st2 = 1'b1;
        dec_n = 0; we_n = 0; err_n = 0; dc = -1; ec = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_in);
            st2 = 1'b0;
            if (dec2) dec_n++;
            if (we2) we_n++;
            if (err2) begin err_n++; ec = i; end
            if (done2 && dc < 0) dc = i;
        end
        check("timeout done cycle", dc, 6);
        check("timeout err cycle", ec, 6);
        check("timeout err pulses", err_n, 1);
        check("timeout dec count", dec_n, 1);
        check("timeout we cycles", we_n, 4);
        check("timeout busy after", busy2, 1'b0);

        // asynchronous reset in the middle of a push
        set_regs(1'b1, 1'b1, 16'h0F00);
        @(negedge clk_in);
        start = 1'b1; pull = 1'b0; use_s_i = 1'b1; mask = 8'hFF;
        @(negedge clk_in) start = 1'b0;
        repeat (4) @(negedge clk_in);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("midrst ctrl", {busy, done, err, mem_we, mem_oe, inc_su, dec_su, write_reg, use_s}, 0);
        check("midrst addr", {path_left_addr, write_reg_addr, mem_addr, mem_dout, data_w}, 0);
        @(negedge clk_in) rst_in = 1'b0;
        set_regs(1'b1, 1'b1, 16'h0F00);
        run_op(1'b0, 1'b1, 8'h3C, 0, "after rst", dc);

        // randomized push/pull pairs with random memory stalls
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 16; i++) ld_vals[i] = 16'($urandom);
            us = 1'($urandom_range(0, 1));
            sp0 = 16'($urandom);
            ld_vals[us ? 4 : 3] = sp0;
            do_load();
            run_op(1'b0, us, 8'($urandom), 1, $sformatf("rnd%0d push", r), dc);
            run_op(1'b1, us, 8'($urandom), 1, $sformatf("rnd%0d pull", r), dc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
